instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
- Instruction-fetch stage that sits directly upstream of the single-cycle R-type datapath and drives its 32-bit `instruccion` input.
- Holds the program counter and a word-addressed instruction memory, loaded through a programming port.
- Issues one registered instruction per cycle, with stall, redirect (branch/jump target) and fault handling.
- Counts issued instructions.

Parameters:
- DEPTH, 64, number of 32-bit instruction words in memory (power of two, ≥ 2).
- RESET_PC, 32'h0000_0000, byte address loaded into PC on reset (word-aligned).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold PC and outputs this cycle.
- redirect  in  1  load redirect_pc into PC; inserts a bubble.
- redirect_pc  in  32  byte-address target for redirect.
- prog_we  in  1  instruction-memory write enable.
- prog_addr  in  $clog2(DEPTH)  word index for programming write.
- prog_data  in  32  word to write.
- instruccion  out  32  fetched instruction; feeds datapath instruccion.
- pc_out  out  32  byte address of the word in instruccion.
- valid  out  1  instruccion is a real issued instruction.
- fault  out  1  sticky; PC left memory range or redirect target misaligned.
- fetch_count  out  32  number of instructions issued with valid=1.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst); sampled only on rising clk.
- Reset values:
  - PC = RESET_PC; instruccion = 0; pc_out = 0; valid = 0; fault = 0; fetch_count = 0; state = RUN.
  - Memory contents are not cleared.
- rst has priority over every other input, including mid-stall, mid-redirect and in FAULT.
- States: RUN, FAULT.
- RUN, evaluated each cycle in this priority order:
  1. redirect=1 (wins over stall):
     - redirect_pc[1:0] ≠ 0: go FAULT, fault<=1, valid<=0, instruccion<=0.
     - else: PC<=redirect_pc, valid<=0, instruccion<=0, pc_out unchanged.
     - First instruction from the target appears the cycle after next.
  2. stall=1: PC, instruccion, pc_out, valid and fetch_count all hold.
  3. Otherwise, PC word index PC[31:2] ≥ DEPTH: go FAULT, fault<=1, valid<=0, instruccion<=0.
  4. Otherwise (normal issue):
     - instruccion<=mem[PC[$clog2(DEPTH)+1:2]], pc_out<=PC, valid<=1.
     - PC<=PC+4 (modulo 2^32).
     - fetch_count<=fetch_count+1 (wraps at 2^32).
- Latency: one cycle from PC value to registered instruccion. Back-to-back issue every unstalled cycle.
- FAULT:
  - PC and pc_out frozen; valid=0; instruccion=0; fetch_count frozen; fault=1.
  - stall and redirect ignored. Exit only via rst.
- Programming port:
  - prog_we writes mem[prog_addr]<=prog_data on the clock edge. Accepted in any state and during rst.
  - Same-cycle write and fetch of the same word: fetch returns the OLD contents (read-before-write).
- instruccion=0 while valid=0 is the bubble value. The datapath must treat valid=0 as no-op; this block does not gate downstream write enables.
- Memory reads are synchronous to the registered output. No combinational path from any input to any output.

Test Plan:
- Load mem[0..3] = 32'h00221820, 32'h00642022, 32'h00A62824, 32'h00E83025; release rst -> over 4 cycles instruccion follows that order, pc_out 0,4,8,C, valid=1 each cycle, fetch_count=4.
- Stall held 3 cycles while instruccion=mem[1] -> instruccion, pc_out=4, valid and fetch_count unchanged for 3 cycles; resume issues mem[2] at pc_out=8.
- Redirect and stall asserted together, redirect_pc=32'h10 -> next cycle valid=0, instruccion=0; following cycle instruccion=mem[4], pc_out=32'h10.
- redirect_pc=32'h6 -> fault=1, valid=0 next cycle; later stall/redirect pulses leave fault=1; rst clears fault, PC=RESET_PC, fetch_count=0.
- DEPTH=64, free-run from 0 -> 64 valid issues (pc_out up to 32'hFC), then fault=1 with valid=0, fetch_count=64.
- prog_we writes 32'hDEADBEEF to word 2 on the same edge word 2 is fetched -> old word issued; after redirect to 8, 32'hDEADBEEF is issued.

Source files
------------

// File: rtl/instr_fetch_if.sv
// Fetch-stage bundle: control/programming inputs toward instr_fetch, registered fetch results back.
// master = driver of stall/redirect/programming (pipeline control); slave = instr_fetch itself.
interface instr_fetch_if #(
    parameter int DEPTH = 64
);
    localparam int AW = $clog2(DEPTH);

    logic          stall;
    logic          redirect;
    logic [31:0]   redirect_pc;
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [31:0]   prog_data;

    logic [31:0]   instruccion;
    logic [31:0]   pc_out;
    logic          valid;
    logic          fault;
    logic [31:0]   fetch_count;

    modport master (
        output stall, redirect, redirect_pc, prog_we, prog_addr, prog_data,
        input  instruccion, pc_out, valid, fault, fetch_count
    );

    modport slave (
        input  stall, redirect, redirect_pc, prog_we, prog_addr, prog_data,
        output instruccion, pc_out, valid, fault, fetch_count
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: PC + word-addressed instruction memory, one registered issue per cycle (1-cycle latency).
// stall holds PC and all outputs; redirect inserts one bubble; a fault is sticky until rst.
module instr_fetch #(
    parameter int          DEPTH    = 64,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst,
    instr_fetch_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {RUN, FAULT} state_t;

    state_t        state;
    logic [31:0]   pc;
    logic [31:0]   mem [DEPTH];
    logic [31:0]   instr_q;
    logic [31:0]   pc_out_q;
    logic          valid_q;
    logic          fault_q;
    logic [31:0]   count_q;

    logic [AW-1:0] widx;
    logic          out_of_range;

    assign widx         = pc[AW+1:2];
    // Any PC bit above the memory's word index means the word index is >= DEPTH.
    assign out_of_range = |pc[31:AW+2];

    // Programming port is never blocked by reset or state; the fetch below reads the pre-edge word.
    always_ff @(posedge clk) begin
        if (bus.prog_we) begin
            mem[bus.prog_addr] <= bus.prog_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            pc       <= RESET_PC;
            instr_q  <= '0;
            pc_out_q <= '0;
            valid_q  <= 1'b0;
            fault_q  <= 1'b0;
            count_q  <= '0;
        end else if (state == RUN) begin
            if (bus.redirect) begin
                valid_q <= 1'b0;
                instr_q <= '0;
                if (bus.redirect_pc[1:0] != 2'b00) begin
                    state   <= FAULT;
                    fault_q <= 1'b1;
                end else begin
                    pc <= bus.redirect_pc;
                end
            end else if (!bus.stall) begin
                if (out_of_range) begin
                    state   <= FAULT;
                    fault_q <= 1'b1;
                    valid_q <= 1'b0;
                    instr_q <= '0;
                end else begin
                    instr_q  <= mem[widx];
                    pc_out_q <= pc;
                    valid_q  <= 1'b1;
                    pc       <= pc + 32'd4;
                    count_q  <= count_q + 32'd1;
                end
            end
        end
    end

    assign bus.instruccion = instr_q;
    assign bus.pc_out      = pc_out_q;
    assign bus.valid       = valid_q;
    assign bus.fault       = fault_q;
    assign bus.fetch_count = count_q;
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed vector table, hand-written fault/overrun sequences, then random vs reference model.
module tb_instr_fetch;
    localparam int DEPTH = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    instr_fetch_if #(.DEPTH(DEPTH)) bus ();

    instr_fetch #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference model: architectural view only (PC, memory image, last issued record).
    logic [31:0] m_mem [DEPTH];
    logic [31:0] m_pc, m_ins, m_pcout, m_cnt;
    bit          m_vld, m_flt;

    task automatic model_step();
        if (rst) begin
            m_pc = 32'h0; m_ins = 0; m_pcout = 0; m_vld = 0; m_flt = 0; m_cnt = 0;
        end else if (!m_flt) begin
            if (bus.redirect) begin
                m_vld = 0; m_ins = 0;
                if (bus.redirect_pc % 4 != 0) m_flt = 1;
                else m_pc = bus.redirect_pc;
            end else if (!bus.stall) begin
                if ((m_pc / 4) >= DEPTH) begin
                    m_flt = 1; m_vld = 0; m_ins = 0;
                end else begin
                    m_ins = m_mem[m_pc / 4]; m_pcout = m_pc; m_vld = 1;
                    m_pc = m_pc + 4; m_cnt = m_cnt + 1;
                end
            end
        end
        if (bus.prog_we) m_mem[int'(bus.prog_addr)] = bus.prog_data;
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input logic [31:0] ins, input logic [31:0] pc, input bit v,
                           input bit f, input logic [31:0] cnt, input string tag);
        chk({tag, ".instruccion"}, bus.instruccion, ins);
        chk({tag, ".pc_out"}, bus.pc_out, pc);
        chk({tag, ".valid"}, {31'b0, bus.valid}, {31'b0, v});
        chk({tag, ".fault"}, {31'b0, bus.fault}, {31'b0, f});
        chk({tag, ".fetch_count"}, bus.fetch_count, cnt);
    endtask

    task automatic idle_inputs();
        bus.stall = 0; bus.redirect = 0; bus.redirect_pc = 0;
        bus.prog_we = 0; bus.prog_addr = '0; bus.prog_data = 0;
    endtask

    typedef struct {
        bit          stall;
        bit          redir;
        logic [31:0] rpc;
        bit          we;
        int          paddr;
        logic [31:0] pdata;
        logic [31:0] e_ins;
        logic [31:0] e_pc;
        bit          e_v;
        bit          e_f;
        logic [31:0] e_cnt;
    } vec_t;

    function automatic vec_t mk(bit s, bit r, logic [31:0] rpc, bit we, int pa, logic [31:0] pd,
                                logic [31:0] ins, logic [31:0] pc, bit v, bit f, logic [31:0] cnt);
        vec_t t;
        t.stall = s; t.redir = r; t.rpc = rpc; t.we = we; t.paddr = pa; t.pdata = pd;
        t.e_ins = ins; t.e_pc = pc; t.e_v = v; t.e_f = f; t.e_cnt = cnt;
        return t;
    endfunction

    localparam logic [31:0] P0 = 32'h00221820, P1 = 32'h00642022,
                            P2 = 32'h00A62824, P3 = 32'h00E83025;

    function automatic logic [31:0] init_word(int i);
        case (i)
            0: return P0;
            1: return P1;
            2: return P2;
            3: return P3;
            default: return 32'h1000_0000 | 32'(i);
        endcase
    endfunction

    initial begin
        vec_t tv[$];
        logic [31:0] exp_w;
        int r;

        idle_inputs();
        rst = 1;
        for (int i = 0; i < DEPTH; i++) begin
            bus.prog_we = 1; bus.prog_addr = 6'(i); bus.prog_data = init_word(i);
            cyc();
        end
        idle_inputs();
        cyc();
        chk_all(0, 0, 0, 0, 0, "reset");

        //            s  r  rpc    we pa pdata          ins           pc      v  f  cnt
        tv.push_back(mk(0, 0, 0,     0, 0, 0,           P0,           32'h0,  1, 0, 1));
        tv.push_back(mk(0, 0, 0,     0, 0, 0,           P1,           32'h4,  1, 0, 2));
        tv.push_back(mk(0, 0, 0,     0, 0, 0,           P2,           32'h8,  1, 0, 3));
        tv.push_back(mk(0, 0, 0,     0, 0, 0,           P3,           32'hC,  1, 0, 4));
        tv.push_back(mk(0, 1, 32'h4, 0, 0, 0,           0,            32'hC,  0, 0, 4));
        tv.push_back(mk(0, 0, 0,     0, 0, 0,           P1,           32'h4,  1, 0, 5));
        tv.push_back(mk(1, 0, 0,     0, 0, 0,           P1,           32'h4,  1, 0, 5));
        tv.push_back(mk(1, 0, 0,     0, 0, 0,           P1,           32'h4,  1, 0, 5));
        tv.push_back(mk(1, 0, 0,     0, 0, 0,           P1,           32'h4,  1, 0, 5));
        tv.push_back(mk(0, 0, 0,     0, 0, 0,           P2,           32'h8,  1, 0, 6));
        tv.push_back(mk(1, 1, 32'h10,0, 0, 0,           0,            32'h8,  0, 0, 6));
        tv.push_back(mk(0, 0, 0,     0, 0, 0,           32'h10000004, 32'h10, 1, 0, 7));
        tv.push_back(mk(0, 1, 32'h8, 0, 0, 0,           0,            32'h10, 0, 0, 7));
        tv.push_back(mk(0, 0, 0,     1, 2, 32'hDEADBEEF,P2,           32'h8,  1, 0, 8));
        tv.push_back(mk(0, 1, 32'h8, 0, 0, 0,           0,            32'h8,  0, 0, 8));
        tv.push_back(mk(0, 0, 0,     0, 0, 0,           32'hDEADBEEF, 32'h8,  1, 0, 9));
        tv.push_back(mk(0, 1, 32'h6, 0, 0, 0,           0,            32'h8,  0, 1, 9));
        tv.push_back(mk(1, 0, 0,     0, 0, 0,           0,            32'h8,  0, 1, 9));
        tv.push_back(mk(0, 1, 32'h10,0, 0, 0,           0,            32'h8,  0, 1, 9));
        tv.push_back(mk(0, 0, 0,     0, 0, 0,           0,            32'h8,  0, 1, 9));

        rst = 0;
        foreach (tv[i]) begin
            bus.stall = tv[i].stall; bus.redirect = tv[i].redir; bus.redirect_pc = tv[i].rpc;
            bus.prog_we = tv[i].we; bus.prog_addr = 6'(tv[i].paddr); bus.prog_data = tv[i].pdata;
            cyc();
            chk_all(tv[i].e_ins, tv[i].e_pc, tv[i].e_v, tv[i].e_f, tv[i].e_cnt, $sformatf("vec%0d", i));
        end
        idle_inputs();

        // rst clears a sticky fault
        rst = 1; cyc();
        chk_all(0, 0, 0, 0, 0, "rst_from_fault");
        rst = 0;

        // Free-run across the whole memory, then overrun into fault
        for (int i = 0; i < DEPTH; i++) begin
            cyc();
            exp_w = (i == 2) ? 32'hDEADBEEF : init_word(i);
            chk_all(exp_w, 32'(i * 4), 1, 0, 32'(i + 1), $sformatf("run%0d", i));
        end
        cyc();
        chk_all(0, 32'hFC, 0, 1, 64, "overrun");
        bus.redirect = 1; bus.redirect_pc = 32'h0; cyc();
        chk_all(0, 32'hFC, 0, 1, 64, "overrun_redirect_ignored");
        idle_inputs();

        // Randomized traffic against the reference model
        rst = 1; cyc(); rst = 0;
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            bus.stall = ($urandom_range(0, 3) == 0);
            bus.redirect = ($urandom_range(0, 9) == 0);
            r = int'($urandom_range(0, 99));
            if (r < 85)      bus.redirect_pc = 32'($urandom_range(0, DEPTH - 1)) * 4;
            else if (r < 95) bus.redirect_pc = 32'(DEPTH * 4) + 32'($urandom_range(0, 15)) * 4;
            else             bus.redirect_pc = ($urandom & 32'hFC) | 32'($urandom_range(1, 3));
            bus.prog_we = ($urandom_range(0, 4) == 0);
            bus.prog_addr = 6'($urandom_range(0, DEPTH - 1));
            bus.prog_data = $urandom;
            cyc();
            chk_all(m_ins, m_pcout, m_vld, m_flt, m_cnt, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
